// File: rtl/rr_arb_lock_pkg.sv
// Shared types and helpers for the packet-locked round-robin arbiter.
package rr_arb_lock_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } rr_arb_state_t;

  // Widest requester vector the mask helper can describe.
  localparam int unsigned MAX_W = 64;

  // Mask with ones strictly above bit idx; idx == top bit yields all zeros.
  function automatic logic [MAX_W-1:0] above_mask(input int unsigned idx);
    logic [MAX_W-1:0] ones;
    ones = '1;
    return (ones << idx) << 1;
  endfunction

endpackage

// File: rtl/rr_arb_lock_pri.sv
// Priority selector: one-hot of the lowest (or highest) set request bit.
module pri #(
  parameter int W        = 4,
  parameter bit FROM_LSB = 1'b1
) (
  input  logic [W-1:0] i_req,
  output logic [W-1:0] o_gnt
);

  always_comb begin
    o_gnt = '0;
    if (FROM_LSB) begin
      // Scanning downwards lets the lowest set bit overwrite earlier hits.
      for (int i = W - 1; i >= 0; i--) begin
        if (i_req[i]) begin
          o_gnt    = '0;
          o_gnt[i] = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < W; i++) begin
        if (i_req[i]) begin
          o_gnt    = '0;
          o_gnt[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rr_arb_lock.sv
// Round-robin arbiter whose registered grant stays locked until the winner's
// last beat is accepted; a release can hand over to the next winner on the same edge.
module rr_arb_lock
  import rr_arb_lock_pkg::*;
#(
  parameter  int W  = 4,
  localparam int EW = (W > 1) ? $clog2(W) : 1
) (
  input  logic          clk,
  input  logic          arst,
  input  logic [W-1:0]  i_req,
  input  logic [W-1:0]  i_last,
  output logic [W-1:0]  o_gnt,
  output logic [EW-1:0] o_gnt_enc,
  output logic          o_vld,
  input  logic          i_rdy,
  output logic [W-1:0]  o_ack
);

  rr_arb_state_t state_q, state_d;
  logic [W-1:0]  gnt_q, gnt_d;
  logic [W-1:0]  mask_q, mask_d;

  logic [EW-1:0] gnt_enc;
  logic [W-1:0]  rel_mask;
  logic [W-1:0]  sel_req;
  logic [W-1:0]  sel_mask;
  logic [W-1:0]  req_masked;
  logic [W-1:0]  gnt_masked;
  logic [W-1:0]  gnt_unmasked;
  logic [W-1:0]  pick;
  logic          is_release;

  always_comb begin
    gnt_enc = '0;
    for (int i = 0; i < W; i++) begin
      if (gnt_q[i]) gnt_enc = EW'(i);
    end
  end

  assign rel_mask   = W'(above_mask(32'(gnt_enc)));
  assign is_release = (state_q == BUSY) && i_rdy && |(i_last & gnt_q);

  // On release the current winner is excluded and the search starts above it.
  always_comb begin
    if (state_q == BUSY) begin
      sel_req  = i_req & ~gnt_q;
      sel_mask = rel_mask;
    end else begin
      sel_req  = i_req;
      sel_mask = mask_q;
    end
  end

  assign req_masked = sel_req & sel_mask;

  pri #(.W(W), .FROM_LSB(1'b1)) u_pri_masked (
    .i_req (req_masked),
    .o_gnt (gnt_masked)
  );

  pri #(.W(W), .FROM_LSB(1'b1)) u_pri_unmasked (
    .i_req (sel_req),
    .o_gnt (gnt_unmasked)
  );

  assign pick = (|req_masked) ? gnt_masked : gnt_unmasked;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    mask_d  = mask_q;
    case (state_q)
      IDLE: begin
        if (|i_req) begin
          gnt_d   = pick;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (is_release) begin
          mask_d = rel_mask;
          gnt_d  = pick;
          if (pick == '0) state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      mask_q  <= '1;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      mask_q  <= mask_d;
    end
  end

  assign o_gnt     = gnt_q;
  assign o_gnt_enc = gnt_enc;
  assign o_vld     = (state_q == BUSY);
  assign o_ack     = gnt_q & {W{i_rdy}};

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (arst)
    $onehot0(gnt_q));

  a_gnt_locked: assert property (@(posedge clk) disable iff (arst)
    (o_vld && !(i_rdy && i_last[gnt_enc])) |=> $stable(gnt_q));

  a_gnt_in_req: assert property (@(posedge clk) disable iff (arst)
    o_vld |-> ((gnt_q & ~i_req) == '0));

  a_last_known: assert property (@(posedge clk) disable iff (arst)
    o_vld |-> !$isunknown(i_last[gnt_enc]));

endmodule

// File: tb/tb_rr_arb_lock.sv
// Directed vector table plus randomized traffic against a rotating-pointer model.
module tb_rr_arb_lock;

  localparam int W  = 4;
  localparam int EW = 2;

  logic          clk = 1'b0;
  logic          arst;
  logic [W-1:0]  i_req;
  logic [W-1:0]  i_last;
  logic [W-1:0]  o_gnt;
  logic [EW-1:0] o_gnt_enc;
  logic          o_vld;
  logic          i_rdy;
  logic [W-1:0]  o_ack;

  always #5 clk = ~clk;

  rr_arb_lock #(.W(W)) dut (
    .clk       (clk),
    .arst      (arst),
    .i_req     (i_req),
    .i_last    (i_last),
    .o_gnt     (o_gnt),
    .o_gnt_enc (o_gnt_enc),
    .o_vld     (o_vld),
    .i_rdy     (i_rdy),
    .o_ack     (o_ack)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic int enc_of(input logic [W-1:0] g);
    for (int i = 0; i < W; i++) if (g[i]) return i;
    return 0;
  endfunction

  task automatic check_outs(input string tag, input logic [W-1:0] eg);
    chk({tag, " gnt"}, 32'(o_gnt), 32'(eg));
    chk({tag, " enc"}, 32'(o_gnt_enc), 32'(enc_of(eg)));
    chk({tag, " vld"}, 32'(o_vld), 32'(|eg));
  endtask

  // Reference model: granted index (-1 idle) and rotating search start.
  int m_gidx;
  int m_ptr;

  function automatic int rr_pick(input logic [W-1:0] r, input int ptr);
    for (int k = 0; k < W; k++) begin
      int idx;
      idx = (ptr + k) % W;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] model_gnt();
    logic [W-1:0] g;
    g = '0;
    if (m_gidx >= 0) g[m_gidx] = 1'b1;
    return g;
  endfunction

  // Advances the model by one clock edge; returns 1 when a new packet is granted.
  function automatic bit model_edge(input logic [W-1:0] req, input logic [W-1:0] last,
                                    input logic rdy);
    logic [W-1:0] rest;
    if (m_gidx < 0) begin
      m_gidx = rr_pick(req, m_ptr);
      return m_gidx >= 0;
    end
    if (rdy && last[m_gidx]) begin
      m_ptr = (m_gidx + 1) % W;
      rest  = req;
      rest[m_gidx] = 1'b0;
      m_gidx = rr_pick(rest, m_ptr);
      return m_gidx >= 0;
    end
    return 1'b0;
  endfunction

  typedef struct {
    logic [W-1:0] req;
    logic [W-1:0] last;
    logic         rdy;
    logic [W-1:0] gnt;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [W-1:0] req, input logic [W-1:0] last,
                              input logic rdy, input logic [W-1:0] gnt);
    vec_t v;
    v.req = req; v.last = last; v.rdy = rdy; v.gnt = gnt;
    tbl.push_back(v);
  endfunction

  task automatic apply(input string tag, input logic [W-1:0] req, input logic [W-1:0] last,
                       input logic rdy, input logic [W-1:0] prev, input logic [W-1:0] eg);
    i_req = req; i_last = last; i_rdy = rdy;
    #1;
    chk({tag, " ack"}, 32'(o_ack), 32'(prev & {W{rdy}}));
    @(posedge clk); #1;
    check_outs(tag, eg);
  endtask

  int           rem  [W];
  int           waitc[W];
  logic [W-1:0] req_r, last_r;
  logic         rdy_r;
  int           old_g;
  bit           new_g;
  logic [W-1:0] prev;

  initial begin
    arst = 1'b1; i_req = '0; i_last = '0; i_rdy = 1'b1;
    #1;
    check_outs("reset", '0);
    chk("reset ack", 32'(o_ack), 32'h0);
    repeat (2) @(posedge clk);
    #1 arst = 1'b0;
    for (int c = 0; c < 3; c++) apply($sformatf("idle%0d", c), '0, '0, 1'b1, '0, '0);

    // Full rotation, then release to idle.
    add(4'b1111, 4'b1111, 1'b1, 4'b0001);
    add(4'b1111, 4'b1111, 1'b1, 4'b0010);
    add(4'b1111, 4'b1111, 1'b1, 4'b0100);
    add(4'b1111, 4'b1111, 1'b1, 4'b1000);
    add(4'b1111, 4'b1111, 1'b1, 4'b0001);
    add(4'b0001, 4'b0001, 1'b1, 4'b0000);
    // Packet lock on requester 0 while requester 2 waits.
    add(4'b0001, 4'b0000, 1'b0, 4'b0001);
    add(4'b0101, 4'b0000, 1'b1, 4'b0001);
    add(4'b0101, 4'b0000, 1'b1, 4'b0001);
    add(4'b0101, 4'b0000, 1'b1, 4'b0001);
    add(4'b0101, 4'b0001, 1'b1, 4'b0100);
    add(4'b0110, 4'b0100, 1'b1, 4'b0010);
    // Backpressure with a changing request set.
    for (int k = 0; k < 5; k++) add(4'b1011, 4'b1111, 1'b0, 4'b0010);
    add(4'b1011, 4'b0010, 1'b1, 4'b1000);
    // Wrap from the top requester, then a sole requester releasing.
    add(4'b1001, 4'b1000, 1'b1, 4'b0001);
    add(4'b0101, 4'b0001, 1'b1, 4'b0100);
    add(4'b0100, 4'b0100, 1'b1, 4'b0000);
    add(4'b0100, 4'b0000, 1'b0, 4'b0100);
    add(4'b0100, 4'b0100, 1'b1, 4'b0000);
    add(4'b0000, 4'b0000, 1'b1, 4'b0000);
    add(4'b0000, 4'b0000, 1'b1, 4'b0000);

    prev = '0;
    for (int i = 0; i < tbl.size(); i++) begin
      apply($sformatf("tbl%0d", i), tbl[i].req, tbl[i].last, tbl[i].rdy, prev, tbl[i].gnt);
      prev = tbl[i].gnt;
    end

    // Mid-packet reset clears at once and restores requester-0 priority.
    apply("prerst", 4'b1010, '0, 1'b0, '0, 4'b1000);
    i_req = 4'b1010; i_last = '0; i_rdy = 1'b1;
    #1 arst = 1'b1;
    #1;
    check_outs("midrst", '0);
    chk("midrst ack", 32'(o_ack), 32'h0);
    #2 arst = 1'b0;
    @(posedge clk); #1;
    check_outs("postrst", 4'b0010);
    apply("postrst2", 4'b1010, 4'b0010, 1'b1, 4'b0010, 4'b1000);
    apply("postrst3", 4'b1000, 4'b1000, 1'b1, 4'b1000, 4'b0000);

    // Randomized traffic against the model.
    arst = 1'b1; i_req = '0; i_last = '0;
    #2 arst = 1'b0;
    m_gidx = -1; m_ptr = 0;
    for (int i = 0; i < W; i++) begin rem[i] = 0; waitc[i] = 0; end
    @(posedge clk); #1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < W; i++) begin
        if (rem[i] == 0 && ($urandom % 4) == 0) rem[i] = 1 + int'($urandom % 4);
        req_r[i]  = (rem[i] != 0);
        last_r[i] = (i == m_gidx) ? (rem[i] == 1) : 1'($urandom % 2);
      end
      rdy_r = (($urandom % 4) != 0);
      i_req = req_r; i_last = last_r; i_rdy = rdy_r;
      #1;
      chk("rnd ack", 32'(o_ack), 32'(model_gnt() & {W{rdy_r}}));
      old_g = m_gidx;
      if (old_g >= 0 && rdy_r) rem[old_g]--;
      new_g = model_edge(req_r, last_r, rdy_r);
      if (new_g) begin
        chk($sformatf("starve r%0d", m_gidx), 32'(waitc[m_gidx] <= W - 1), 32'h1);
        waitc[m_gidx] = 0;
        for (int j = 0; j < W; j++) if (j != m_gidx && req_r[j]) waitc[j]++;
      end
      @(posedge clk); #1;
      check_outs("rnd", model_gnt());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
